bt_cmd_decoder: RTL and testbench
=================================

# bt_cmd_decoder

Parametrised command decoder for the robot's Bluetooth link. It consumes a byte stream from an external UART receiver and drives the following outputs:
- motor command and speed level;
- auto-mode flag;
- vision (HuskyLens arrow) request handshake;
- status LEDs.

Compared with the single-purpose parser it replaces, it adds:
- case-insensitive commands and speed-digit commands;
- a manual-mode link watchdog;
- a busy/done request handshake with timeout;
- configurable periods.

## Interface
- TICK_CYCLES, 1_500_000: auto-mode request period in clk cycles (>=2).
- WDOG_CYCLES, 25_000_000: manual-mode inactivity timeout in clk cycles; 0 disables the watchdog.
- REQ_TIMEOUT, 5_000_000: maximum busy duration in clk cycles before the request is abandoned (>=2).
- SPEED_W, 3: speed output width.
- SPEED_RST, 4: speed reset value (< 2^SPEED_W).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte.
- req_done  in  1  vision request completed (pulse or level).
- motor_state  out  3  000 STOP, 001 FWD, 010 BWD, 011 LEFT, 100 RIGHT, 110 AUTO.
- speed  out  SPEED_W  speed level.
- auto_mode  out  1  auto mode active.
- req_en  out  1  one-cycle request strobe.
- req_busy  out  1  request outstanding.
- wdog_trip  out  1  one-cycle strobe when the watchdog forces STOP.
- led  out  4  status pattern.

## Operation
- All outputs are registered. Reset values: motor_state=000, speed=SPEED_RST, auto_mode=0, req_en=0, req_busy=0, wdog_trip=0, led=0000. All internal counters reset to 0 and prev_byte resets to 8'h00.
- Letter normalisation: bytes 'a'..'z' map to upper case by clearing bit 5 before decoding. Other bytes are unchanged.
- Decode on rx_valid, manual mode (auto_mode=0):
  - 'F'/'B'/'L'/'R'/'S' set FWD/BWD/LEFT/RIGHT/STOP.
  - 'A' sets auto_mode=1 and motor_state=AUTO.
  - 'V' leaves motor_state unchanged.
  - Digit '0'..'9' sets speed = min(digit, 2^SPEED_W-1); motor_state unchanged.
  - Any other byte sets STOP.
- Decode on rx_valid, auto mode:
  - 'A' or 'S' sets auto_mode=0 and motor_state=STOP.
  - Digits update speed.
  - 'F','B','L','R', 'V' and unknown bytes leave motor_state and auto_mode unchanged.
- prev_byte: holds the normalised byte and updates on every rx_valid.
- Periodic timer:
  - Held at 0 while auto_mode=0.
  - In auto mode, counts 0..TICK_CYCLES-1 and wraps; tick asserts when the count equals TICK_CYCLES-1.
  - Cleared on entering or leaving auto mode.
- Request triggers:
  - tick in auto mode;
  - rx_valid with normalised byte 'V' and prev_byte != 'V' (held-button repeats suppressed).
  - Two triggers in the same cycle produce one request.
- Request FSM, IDLE:
  - A trigger pulses req_en for 1 cycle, sets req_busy=1 and moves to BUSY.
  - req_done in IDLE is ignored.
- Request FSM, BUSY:
  - Triggers are dropped (no queue).
  - req_done=1 returns to IDLE with req_busy=0.
  - If req_done does not arrive, the busy counter reaches REQ_TIMEOUT-1 and the FSM returns to IDLE.
  - A trigger in the same cycle as the BUSY→IDLE exit is dropped.
- Watchdog:
  - The counter clears on every rx_valid and while auto_mode=1 or motor_state=STOP.
  - Otherwise it increments; at WDOG_CYCLES-1 it forces motor_state=STOP, pulses wdog_trip and clears.
  - If rx_valid arrives in the same cycle as expiry, the byte wins and there is no trip.
- LED, computed from the next-state values:
  - req_busy=1 gives 0011. This takes priority over the rest.
  - Otherwise by motor_state: STOP 0000, FWD 1000, RIGHT 0001, BWD 0100, LEFT 0010, AUTO 0111.

## Timing
- rx_valid sampled at edge N: motor_state, speed, auto_mode and led are updated at edge N.
- Visible from cycle N+1 onward.
- 'V' trigger at edge N: req_en=1 and req_busy=1 during cycle N+1.
- req_en lasts exactly one cycle.
- req_done sampled at edge M: req_busy=0 from cycle M+1.
- Tick: req_en asserts the cycle after the count equals TICK_CYCLES-1. Steady auto mode with prompt req_done gives one req_en every TICK_CYCLES cycles.
- rst asserted mid-operation returns all state to reset values at the next edge, including any BUSY request and timers.

## Test plan
- Send 'f', then '5', with SPEED_W=3 -> motor_state=001 and led=1000 one cycle after the 'f' strobe; speed=5 one cycle after the '5' strobe. Then send '9' -> speed=7 (clamped).
- Send 'V','V','V', then 'X','V' -> req_en pulses only for the first 'V' and for the 'V' after 'X'. 'X' sets STOP.
- Set TICK_CYCLES=10 and send 'A'; hold req_done=1 -> motor_state=110, led=0111, req_en every 10 cycles. Then send 'S' -> motor_state=000, auto_mode=0, no further req_en.
- Set REQ_TIMEOUT=8 and trigger 'V' without req_done; send 'X','V' while busy -> req_busy=1 for 8 cycles, led=0011, then 0; the second 'V' does not retrigger.
- Set WDOG_CYCLES=20 and send 'R' -> exactly 20 cycles later motor_state=000 and wdog_trip pulses. Repeat, sending 'R' every 15 cycles -> no trip.
- Assert rst while BUSY in auto mode -> all outputs return to reset values next cycle, including speed=SPEED_RST.

Source files
------------

// File: rtl/bt_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bt_cmd_decoder
// Brief    : Bluetooth byte-stream command decoder with link watchdog and a
//            busy/done vision-request handshake.
// Revision : 1.0 - initial release
// ============================================================================

module bt_cmd_decoder #(
    parameter int TICK_CYCLES = 1_500_000,
    parameter int WDOG_CYCLES = 25_000_000,
    parameter int REQ_TIMEOUT = 5_000_000,
    parameter int SPEED_W     = 3,
    parameter int SPEED_RST   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               req_done,
    output logic [2:0]         motor_state,
    output logic [SPEED_W-1:0] speed,
    output logic               auto_mode,
    output logic               req_en,
    output logic               req_busy,
    output logic               wdog_trip,
    output logic [3:0]         led
);

    localparam logic [2:0] c_MS_STOP  = 3'b000;
    localparam logic [2:0] c_MS_FWD   = 3'b001;
    localparam logic [2:0] c_MS_BWD   = 3'b010;
    localparam logic [2:0] c_MS_LEFT  = 3'b011;
    localparam logic [2:0] c_MS_RIGHT = 3'b100;
    localparam logic [2:0] c_MS_AUTO  = 3'b110;

    localparam logic [7:0] c_CH_A = 8'h41;
    localparam logic [7:0] c_CH_B = 8'h42;
    localparam logic [7:0] c_CH_F = 8'h46;
    localparam logic [7:0] c_CH_L = 8'h4C;
    localparam logic [7:0] c_CH_R = 8'h52;
    localparam logic [7:0] c_CH_S = 8'h53;
    localparam logic [7:0] c_CH_V = 8'h56;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    localparam int c_TICK_W = $clog2(TICK_CYCLES);
    localparam int c_TO_W   = $clog2(REQ_TIMEOUT);
    localparam int c_WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_CYCLES - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(REQ_TIMEOUT - 1);
    localparam logic [31:0]         c_SPEED_MAX = 32'((1 << SPEED_W) - 1);
    localparam logic [SPEED_W-1:0]  c_SPEED_RST = SPEED_W'(SPEED_RST);

    logic [2:0]          r_motor;
    logic [SPEED_W-1:0]  r_speed;
    logic                r_auto;
    logic                r_req_en;
    logic                r_req_busy;
    logic                r_wdog_trip;
    logic [3:0]          r_led;
    logic [7:0]          r_prev;
    logic [0:0]          r_state;
    logic [c_TO_W-1:0]   r_busy_cnt;
    logic [c_TICK_W-1:0] r_tick_cnt;

    logic [7:0]          w_norm;
    logic                w_is_digit;
    logic [31:0]         w_digit32;
    logic [SPEED_W-1:0]  w_digit_spd;
    logic [2:0]          w_motor_n;
    logic [SPEED_W-1:0]  w_speed_n;
    logic                w_auto_n;
    logic                w_tick;
    logic                w_v_trig;
    logic                w_trigger;
    logic                w_wdog_expire;
    logic [0:0]          w_state_n;
    logic [c_TO_W-1:0]   w_busy_cnt_n;
    logic                w_req_en_n;
    logic                w_busy_n;
    logic [3:0]          w_led_n;

    // Lower-case letters differ from upper case only in bit 5.
    assign w_norm      = (rx_data >= 8'h61 && rx_data <= 8'h7A) ? (rx_data & 8'hDF) : rx_data;
    assign w_is_digit  = (w_norm >= 8'h30) && (w_norm <= 8'h39);
    assign w_digit32   = {28'd0, w_norm[3:0]};
    assign w_digit_spd = (w_digit32 > c_SPEED_MAX) ? {SPEED_W{1'b1}} : w_digit32[SPEED_W-1:0];

    assign w_tick    = r_auto && (r_tick_cnt == c_TICK_LAST);
    assign w_v_trig  = rx_valid && (w_norm == c_CH_V) && (r_prev != c_CH_V);
    assign w_trigger = w_tick || w_v_trig;

    always_comb begin
        w_motor_n = r_motor;
        w_speed_n = r_speed;
        w_auto_n  = r_auto;
        if (rx_valid) begin
            if (w_is_digit) begin
                w_speed_n = w_digit_spd;
            end else if (!r_auto) begin
                case (w_norm)
                    c_CH_F:  w_motor_n = c_MS_FWD;
                    c_CH_B:  w_motor_n = c_MS_BWD;
                    c_CH_L:  w_motor_n = c_MS_LEFT;
                    c_CH_R:  w_motor_n = c_MS_RIGHT;
                    c_CH_S:  w_motor_n = c_MS_STOP;
                    c_CH_A: begin
                        w_auto_n  = 1'b1;
                        w_motor_n = c_MS_AUTO;
                    end
                    c_CH_V:  w_motor_n = r_motor;
                    default: w_motor_n = c_MS_STOP;
                endcase
            end else if (w_norm == c_CH_A || w_norm == c_CH_S) begin
                w_auto_n  = 1'b0;
                w_motor_n = c_MS_STOP;
            end
        end else if (w_wdog_expire) begin
            w_motor_n = c_MS_STOP;
        end
    end

    // Request handshake; triggers arriving while BUSY are simply dropped.
    always_comb begin
        w_state_n    = r_state;
        w_busy_cnt_n = r_busy_cnt;
        w_req_en_n   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_trigger) begin
                    w_state_n    = c_ST_BUSY;
                    w_req_en_n   = 1'b1;
                    w_busy_cnt_n = '0;
                end
            end
            c_ST_BUSY: begin
                if (req_done || (r_busy_cnt == c_TO_LAST)) begin
                    w_state_n    = c_ST_IDLE;
                    w_busy_cnt_n = '0;
                end else begin
                    w_busy_cnt_n = r_busy_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n    = c_ST_IDLE;
                w_busy_cnt_n = '0;
            end
        endcase
    end

    assign w_busy_n = (w_state_n == c_ST_BUSY);

    always_comb begin
        w_led_n = 4'b0000;
        if (w_busy_n) begin
            w_led_n = 4'b0011;
        end else begin
            case (w_motor_n)
                c_MS_FWD:   w_led_n = 4'b1000;
                c_MS_RIGHT: w_led_n = 4'b0001;
                c_MS_BWD:   w_led_n = 4'b0100;
                c_MS_LEFT:  w_led_n = 4'b0010;
                c_MS_AUTO:  w_led_n = 4'b0111;
                default:    w_led_n = 4'b0000;
            endcase
        end
    end

    generate
        if (WDOG_CYCLES > 0) begin : g_wdog
            localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYCLES - 1);
            logic [c_WDOG_W-1:0] r_wdog_cnt;

            // A received byte always wins over a coincident expiry.
            assign w_wdog_expire = !rx_valid && !r_auto && (r_motor != c_MS_STOP)
                                   && (r_wdog_cnt == c_WDOG_LAST);

            always_ff @(posedge clk) begin
                if (rst || rx_valid || r_auto || (r_motor == c_MS_STOP) || w_wdog_expire) begin
                    r_wdog_cnt <= '0;
                end else begin
                    r_wdog_cnt <= r_wdog_cnt + 1'b1;
                end
            end
        end else begin : g_no_wdog
            assign w_wdog_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_motor     <= c_MS_STOP;
            r_speed     <= c_SPEED_RST;
            r_auto      <= 1'b0;
            r_req_en    <= 1'b0;
            r_req_busy  <= 1'b0;
            r_wdog_trip <= 1'b0;
            r_led       <= 4'b0000;
            r_prev      <= 8'h00;
            r_state     <= c_ST_IDLE;
            r_busy_cnt  <= '0;
            r_tick_cnt  <= '0;
        end else begin
            r_motor     <= w_motor_n;
            r_speed     <= w_speed_n;
            r_auto      <= w_auto_n;
            r_req_en    <= w_req_en_n;
            r_req_busy  <= w_busy_n;
            r_wdog_trip <= w_wdog_expire;
            r_led       <= w_led_n;
            r_state     <= w_state_n;
            r_busy_cnt  <= w_busy_cnt_n;
            if (rx_valid) begin
                r_prev <= w_norm;
            end
            // Timer restarts from zero on every auto-mode entry and exit.
            if (!(r_auto && w_auto_n) || (r_tick_cnt == c_TICK_LAST)) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    assign motor_state = r_motor;
    assign speed       = r_speed;
    assign auto_mode   = r_auto;
    assign req_en      = r_req_en;
    assign req_busy    = r_req_busy;
    assign wdog_trip   = r_wdog_trip;
    assign led         = r_led;

endmodule

`default_nettype wire

// File: tb/tb_bt_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bt_cmd_decoder
// Brief    : Directed vector bench for bt_cmd_decoder (TICK=10, WDOG=20, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================

module tb_bt_cmd_decoder;

    localparam int c_TICK    = 10;
    localparam int c_WDOG    = 20;
    localparam int c_TO      = 8;
    localparam int c_SPEED_W = 3;

    localparam logic [2:0] STP = 3'b000;
    localparam logic [2:0] FWD = 3'b001;
    localparam logic [2:0] RGT = 3'b100;
    localparam logic [2:0] AUT = 3'b110;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 req_done;
    logic [2:0]           motor_state;
    logic [c_SPEED_W-1:0] speed;
    logic                 auto_mode;
    logic                 req_en;
    logic                 req_busy;
    logic                 wdog_trip;
    logic [3:0]           led;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        dn;
        int          rep;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    bt_cmd_decoder #(
        .TICK_CYCLES (c_TICK),
        .WDOG_CYCLES (c_WDOG),
        .REQ_TIMEOUT (c_TO),
        .SPEED_W     (c_SPEED_W),
        .SPEED_RST   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .req_done    (req_done),
        .motor_state (motor_state),
        .speed       (speed),
        .auto_mode   (auto_mode),
        .req_en      (req_en),
        .req_busy    (req_busy),
        .wdog_trip   (wdog_trip),
        .led         (led)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] pack(input logic [2:0] m, input logic [2:0] s, input logic a,
                                         input logic re, input logic rb, input logic wt,
                                         input logic [3:0] l);
        return {m, s, a, re, rb, wt, l};
    endfunction

    task automatic add(input logic v, input logic [7:0] d, input logic dn, input int rep,
                       input logic [13:0] exp);
        vec_t e;
        e.v = v; e.d = d; e.dn = dn; e.rep = rep; e.exp = exp;
        tbl.push_back(e);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic dn);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        req_done = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {motor_state, speed, auto_mode, req_en, req_busy, wdog_trip, led};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %b required %b (motor|speed|auto|req_en|busy|trip|led)",
                     name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; req_done = 1'b0;

        // Manual commands, case folding, speed digits with clamp
        add(0, 8'h00, 0, 1,  pack(STP, 3'd4, 0, 0, 0, 0, 4'b0000));
        add(1, 8'h66, 0, 1,  pack(FWD, 3'd4, 0, 0, 0, 0, 4'b1000));   // 'f'
        add(1, 8'h35, 0, 1,  pack(FWD, 3'd5, 0, 0, 0, 0, 4'b1000));   // '5'
        add(1, 8'h39, 0, 1,  pack(FWD, 3'd7, 0, 0, 0, 0, 4'b1000));   // '9' clamps
        add(1, 8'h73, 0, 1,  pack(STP, 3'd7, 0, 0, 0, 0, 4'b0000));   // 's'
        // V repeat suppression, req_done held high
        add(1, 8'h56, 1, 1,  pack(STP, 3'd7, 0, 1, 1, 0, 4'b0011));
        add(1, 8'h56, 1, 1,  pack(STP, 3'd7, 0, 0, 0, 0, 4'b0000));
        add(1, 8'h76, 1, 1,  pack(STP, 3'd7, 0, 0, 0, 0, 4'b0000));
        add(1, 8'h58, 1, 1,  pack(STP, 3'd7, 0, 0, 0, 0, 4'b0000));   // 'X'
        add(1, 8'h56, 1, 1,  pack(STP, 3'd7, 0, 1, 1, 0, 4'b0011));
        add(0, 8'h00, 1, 1,  pack(STP, 3'd7, 0, 0, 0, 0, 4'b0000));
        // Request timeout: busy for exactly 8 cycles, retrigger dropped
        add(1, 8'h58, 0, 1,  pack(STP, 3'd7, 0, 0, 0, 0, 4'b0000));
        add(1, 8'h56, 0, 1,  pack(STP, 3'd7, 0, 1, 1, 0, 4'b0011));
        add(1, 8'h58, 0, 1,  pack(STP, 3'd7, 0, 0, 1, 0, 4'b0011));
        add(1, 8'h56, 0, 1,  pack(STP, 3'd7, 0, 0, 1, 0, 4'b0011));
        add(0, 8'h00, 0, 5,  pack(STP, 3'd7, 0, 0, 1, 0, 4'b0011));
        add(0, 8'h00, 0, 1,  pack(STP, 3'd7, 0, 0, 0, 0, 4'b0000));
        // Watchdog trip 20 cycles after 'r'
        add(1, 8'h72, 0, 1,  pack(RGT, 3'd7, 0, 0, 0, 0, 4'b0001));
        add(0, 8'h00, 0, 19, pack(RGT, 3'd7, 0, 0, 0, 0, 4'b0001));
        add(0, 8'h00, 0, 1,  pack(STP, 3'd7, 0, 0, 0, 1, 4'b0000));
        add(0, 8'h00, 0, 1,  pack(STP, 3'd7, 0, 0, 0, 0, 4'b0000));
        // Refresh every 15 cycles, then a byte coincident with expiry
        add(1, 8'h52, 0, 1,  pack(RGT, 3'd7, 0, 0, 0, 0, 4'b0001));
        add(0, 8'h00, 0, 14, pack(RGT, 3'd7, 0, 0, 0, 0, 4'b0001));
        add(1, 8'h52, 0, 1,  pack(RGT, 3'd7, 0, 0, 0, 0, 4'b0001));
        add(0, 8'h00, 0, 14, pack(RGT, 3'd7, 0, 0, 0, 0, 4'b0001));
        add(1, 8'h52, 0, 1,  pack(RGT, 3'd7, 0, 0, 0, 0, 4'b0001));
        add(0, 8'h00, 0, 19, pack(RGT, 3'd7, 0, 0, 0, 0, 4'b0001));
        add(1, 8'h52, 0, 1,  pack(RGT, 3'd7, 0, 0, 0, 0, 4'b0001));
        add(1, 8'h53, 0, 1,  pack(STP, 3'd7, 0, 0, 0, 0, 4'b0000));
        // Auto mode: periodic requests, 'F' ignored, digit still accepted
        add(1, 8'h61, 1, 1,  pack(AUT, 3'd7, 1, 0, 0, 0, 4'b0111));   // 'a'
        add(0, 8'h00, 1, 4,  pack(AUT, 3'd7, 1, 0, 0, 0, 4'b0111));
        add(1, 8'h46, 1, 1,  pack(AUT, 3'd7, 1, 0, 0, 0, 4'b0111));   // 'F'
        add(1, 8'h32, 1, 1,  pack(AUT, 3'd2, 1, 0, 0, 0, 4'b0111));   // '2'
        add(0, 8'h00, 1, 3,  pack(AUT, 3'd2, 1, 0, 0, 0, 4'b0111));
        add(0, 8'h00, 1, 1,  pack(AUT, 3'd2, 1, 1, 1, 0, 4'b0011));
        add(0, 8'h00, 1, 9,  pack(AUT, 3'd2, 1, 0, 0, 0, 4'b0111));
        add(0, 8'h00, 1, 1,  pack(AUT, 3'd2, 1, 1, 1, 0, 4'b0011));
        add(1, 8'h73, 1, 1,  pack(STP, 3'd2, 0, 0, 0, 0, 4'b0000));   // 's'
        add(0, 8'h00, 1, 15, pack(STP, 3'd2, 0, 0, 0, 0, 4'b0000));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", pack(STP, 3'd4, 0, 0, 0, 0, 4'b0000));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                step(tbl[i].v, tbl[i].d, tbl[i].dn);
                check($sformatf("vec%0d_%0d", i, r), tbl[i].exp);
            end
        end

        // Reset while a request is outstanding in auto mode
        step(1, 8'h61, 0);
        check("auto_enter", pack(AUT, 3'd2, 1, 0, 0, 0, 4'b0111));
        step(1, 8'h56, 0);
        check("auto_v_req", pack(AUT, 3'd2, 1, 1, 1, 0, 4'b0011));
        step(0, 8'h00, 0);
        check("auto_busy", pack(AUT, 3'd2, 1, 0, 1, 0, 4'b0011));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset", pack(STP, 3'd4, 0, 0, 0, 0, 4'b0000));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(0, 8'h00, 0);
            check($sformatf("post_reset_%0d", k), pack(STP, 3'd4, 0, 0, 0, 0, 4'b0000));
        end

        // prev_byte cleared by reset, so a lone 'v' triggers; pulse req_done ends it
        step(1, 8'h76, 0);
        check("v_after_reset", pack(STP, 3'd4, 0, 1, 1, 0, 4'b0011));
        step(0, 8'h00, 0);
        check("busy_hold", pack(STP, 3'd4, 0, 0, 1, 0, 4'b0011));
        step(0, 8'h00, 1);
        check("done_pulse", pack(STP, 3'd4, 0, 0, 0, 0, 4'b0000));
        step(0, 8'h00, 0);
        check("idle_after_done", pack(STP, 3'd4, 0, 0, 0, 0, 4'b0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
